// File: rtl/buf_rd_ctrl.sv
// Burst reader: streams a contiguous (wrapping) range of buffer-RAM words onto a
// valid/ready stream through a 4-entry FIFO, with read issue throttled by FIFO space.
`timescale 1ns/1ps

module buf_rd_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 256,
  parameter int DATA_DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH:0]   len_q;
  logic [ADDR_WIDTH:0]   issued;
  logic [ADDR_WIDTH:0]   issued_inc;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  rd_last;
  logic                  cap_en;
  logic                  cap_last;

  logic [DATA_WIDTH-1:0] fifo_data [4];
  logic [3:0]            fifo_last;
  logic [1:0]            wr_ptr;
  logic [1:0]            rd_ptr;
  logic [2:0]            count;
  logic [3:0]            pending;
  logic                  room;
  logic                  push;
  logic                  pop;

  assign push       = cap_en;
  assign pop        = out_valid & out_ready;
  // Words already queued plus reads still travelling through the RAM pipeline.
  assign pending    = {1'b0, count} + {3'b000, rd_en} + {3'b000, cap_en};
  assign room       = (pending < 4'd4);
  assign issued_inc = issued + {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign next_addr  = (rd_addr == ADDR_WIDTH'(DATA_DEPTH - 1)) ? '0
                    : rd_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  assign out_valid  = (count != 3'd0);
  assign out_data   = out_valid ? fifo_data[rd_ptr] : '0;
  assign out_last   = out_valid & fifo_last[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_en    <= 1'b0;
      rd_addr  <= '0;
      rd_last  <= 1'b0;
      len_q    <= '0;
      issued   <= '0;
      cap_en   <= 1'b0;
      cap_last <= 1'b0;
    end else begin
      done     <= 1'b0;
      cap_en   <= rd_en;
      cap_last <= rd_en & rd_last;
      case (state)
        IDLE: begin
          rd_en <= 1'b0;
          if (start) begin
            if (length == '0) begin
              done <= 1'b1;
            end else begin
              state   <= RUN;
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= base_addr;
              issued  <= {{ADDR_WIDTH{1'b0}}, 1'b1};
              len_q   <= length;
              rd_last <= (length == {{ADDR_WIDTH{1'b0}}, 1'b1});
            end
          end
        end
        RUN: begin
          if (rd_en && (issued == len_q)) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else if ((issued < len_q) && room) begin
            rd_en   <= 1'b1;
            rd_addr <= next_addr;
            issued  <= issued_inc;
            rd_last <= (issued_inc == len_q);
          end else begin
            rd_en <= 1'b0;
          end
        end
        DRAIN: begin
          rd_en <= 1'b0;
          if (pop && out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          rd_en <= 1'b0;
        end
      endcase
    end
  end

  // FIFO bookkeeping; the data array itself needs no reset since it is masked by out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_last <= '0;
    end else begin
      if (push) begin
        wr_ptr            <= wr_ptr + 2'd1;
        fifo_last[wr_ptr] <= cap_last;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_data[wr_ptr] <= rd_data;
  end

endmodule

// File: doc/buf_rd_ctrl.md
BUF_RD_CTRL -- requirements
Module: buf_rd_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, SHALL set the RAM address width.
REQ-002 Parameter DATA_WIDTH, default 256, SHALL set the RAM word and stream data width.
REQ-003 Parameter DATA_DEPTH, default 1024, SHALL set the RAM word count (address wrap point).
REQ-004 clk  in  1  SHALL be the single clock; all state updates on posedge.
REQ-005 rst_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-006 start  in  1  SHALL be a one-cycle burst request, sampled only in IDLE.
REQ-007 base_addr  in  ADDR_WIDTH  SHALL be the first word address, sampled with start.
REQ-008 length  in  ADDR_WIDTH+1  SHALL be the burst word count, sampled with start; 0 is legal.
REQ-009 busy  out  1  SHALL be high whenever state is not IDLE.
REQ-010 done  out  1  SHALL be a one-cycle pulse at burst completion.
REQ-011 rd_addr  out  ADDR_WIDTH  SHALL drive the buffer RAM read address.
REQ-012 rd_en  out  1  SHALL drive the buffer RAM read enable.
REQ-013 rd_data  in  DATA_WIDTH  SHALL be the RAM read word, valid the cycle after rd_en.
REQ-014 out_valid  out  1  SHALL flag a valid stream beat.
REQ-015 out_data  out  DATA_WIDTH  SHALL carry the stream beat.
REQ-016 out_last  out  1  SHALL mark the final beat of a burst; qualified by out_valid.
REQ-017 out_ready  in  1  SHALL be the downstream acceptance; beat transfers when out_valid & out_ready.

Function
REQ-018 The FSM SHALL have states IDLE, RUN, DRAIN.
REQ-019 IDLE -> RUN on start with length>0; IDLE -> IDLE with done pulsed the next cycle on start with length=0, with no rd_en issued.
REQ-020 RUN -> DRAIN in the cycle the last read (issue count = length) is issued; DRAIN -> IDLE on the transfer of the beat carrying out_last.
REQ-021 start while not IDLE SHALL be ignored.
REQ-022 rd_en and rd_addr SHALL be registered; the first rd_en SHALL assert the cycle after start, with rd_addr = base_addr.
REQ-023 Successive reads SHALL use address +1, wrapping from DATA_DEPTH-1 to 0 for any DATA_DEPTH.
REQ-024 Each rd_data word SHALL be written, the cycle after its rd_en, into an internal 4-entry FIFO; out_valid/out_data/out_last SHALL be the FIFO head.
REQ-025 A read SHALL issue only if FIFO occupancy + reads in flight (max 2) < 4, so the FIFO never overflows and no word is dropped or duplicated.
REQ-026 With out_ready held high, the block SHALL sustain one beat per cycle; first out_valid 3 cycles after start (start at T, rd_en at T+1, out_valid at T+3).
REQ-027 Simultaneous FIFO push and pop SHALL keep occupancy unchanged; pop on empty SHALL be impossible.
REQ-028 out_data and out_last SHALL hold stable while out_valid & !out_ready.
REQ-029 out_last SHALL be high only on the length-th beat; done SHALL pulse in the cycle after that beat transfers, with busy low in that same cycle.
REQ-030 rd_en SHALL be low in IDLE and DRAIN.

Reset
REQ-031 On rst_n low: state IDLE, busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_last=0, out_data=0, FIFO empty, counters cleared, asynchronously.
REQ-032 Reset mid-burst SHALL abandon the burst; no done pulse and no stray beat after release; in-flight RAM reads SHALL be discarded.

Verification
REQ-033 start, base_addr=5, length=4, out_ready=1 -> rd_en T+1..T+4, addr 5,6,7,8; beats T+3..T+6 equal to RAM[5..8]; out_last at T+6; done at T+7.
REQ-034 base_addr=DATA_DEPTH-2, length=4 -> addresses DATA_DEPTH-2, DATA_DEPTH-1, 0, 1 in order.
REQ-035 length=16, out_ready toggling 1/0 pseudo-randomly -> 16 beats, correct order, none lost or repeated, FIFO occupancy never >4, out_data stable while stalled.
REQ-036 length=8, out_ready=0 for 10 cycles after start -> exactly 4 reads issued then rd_en low; on ready release, all 8 beats delivered.
REQ-037 start with length=0 -> no rd_en, no out_valid, done pulse next cycle; start during busy -> ignored, burst unaffected.
REQ-038 rst_n low on 3rd beat of length=8 burst -> all outputs zero immediately; after release, new burst base 0 length 2 completes correctly.
